// File: rtl/jtcontra_sdram_pkg.sv
// Shared SDRAM command encodings, mode register value and controller state/request types.
package jtcontra_sdram_pkg;

  // {nCS, nRAS, nCAS, nWE}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  // Burst length 2, sequential, CL2, single-location writes
  localparam logic [12:0] MODE_REG = 13'b000_1_00_010_0_001;

  typedef enum logic [3:0] {
    ST_INIT_WAIT, ST_INIT_PRE, ST_INIT_REF1, ST_INIT_REF2, ST_INIT_MRS,
    ST_IDLE, ST_ACT, ST_RD, ST_WAIT
  } state_t;

  typedef struct packed {
    logic       wr;
    logic [8:0] col;
    logic [7:0] data;
    logic [1:0] mask;
  } req_t;

endpackage

// File: rtl/jtcontra_sdram_refcnt.sv
// Refresh interval timer feeding a saturating count of owed AUTO REFRESH commands.
module jtcontra_sdram_refcnt
  import jtcontra_sdram_pkg::*;
#(
  parameter int REF_CYCLES = 372
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic dec,
  output logic pending,
  output logic urgent
);
  localparam int TW = $clog2(REF_CYCLES + 1);

  logic [TW-1:0] tmr;
  logic [3:0]    pend;
  logic          tick;

  assign tick    = en && (tmr == TW'(REF_CYCLES - 1));
  assign pending = pend != 4'd0;
  assign urgent  = pend == 4'd8;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr  <= '0;
      pend <= 4'd0;
    end else begin
      if (en) tmr <= tick ? '0 : tmr + 1'b1;
      // A tick and a refresh in the same cycle cancel out
      if (tick && !dec && pend != 4'd8)      pend <= pend + 4'd1;
      else if (dec && !tick && pend != 4'd0) pend <= pend - 4'd1;
    end
  end

endmodule

// File: rtl/jtcontra_sdram.sv
// ROM-bus to SDR SDRAM responder: init, refresh scheduling, 32-bit reads, download byte writes.
module jtcontra_sdram
  import jtcontra_sdram_pkg::*;
#(
  parameter int INIT_WAIT  = 4800,
  parameter int REF_CYCLES = 372,
  parameter int TRCD       = 2,
  parameter int TRP        = 2,
  parameter int TRFC       = 7,
  parameter int CL         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_req,
  input  logic [21:0] sdram_addr,
  output logic        sdram_ack,
  output logic        data_rdy,
  output logic [31:0] data_read,
  input  logic        refresh_en,
  input  logic        downloading,
  input  logic        prog_we,
  input  logic [21:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic [1:0]  prog_mask,
  output logic        init_done,
  output logic [3:0]  sd_cmd,
  output logic [12:0] sd_a,
  output logic [1:0]  sd_ba,
  output logic [1:0]  sd_dqm,
  output logic [15:0] sd_dq_out,
  output logic        sd_dq_oe,
  input  logic [15:0] sd_dq_in,
  output logic        sd_cke
);
  localparam int CW = $clog2(INIT_WAIT + TRFC + TRP + CL + 4);

  state_t        st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  req_t          rq, rq_nxt;
  logic [15:0]   dq_r;
  logic [3:0]    cmd_nxt;
  logic [12:0]   a_nxt;
  logic [1:0]    ba_nxt, dqm_nxt;
  logic [15:0]   dq_out_nxt;
  logic          oe_nxt, ack_nxt, rdy_nxt;
  logic [31:0]   rd_nxt;
  logic          ref_pend, ref_urg, ref_dec;

  assign sd_cke = 1'b1;

  jtcontra_sdram_refcnt #(.REF_CYCLES(REF_CYCLES)) u_refcnt (
    .clk(clk), .rst(rst), .en(init_done), .dec(ref_dec),
    .pending(ref_pend), .urgent(ref_urg)
  );

  // Pin values are computed from the next state and registered, so every
  // command leaves the block on the cycle its state is entered.
  // ST_WAIT exits with cnt = delay-2 so the next command from IDLE lands exactly
  // `delay` cycles after the previous one (needs TRP >= 2).
  always_comb begin
    st_nxt     = st;
    cnt_nxt    = (cnt == '0) ? '0 : cnt - 1'b1;
    rq_nxt     = rq;
    cmd_nxt    = CMD_NOP;
    a_nxt      = sd_a;
    ba_nxt     = sd_ba;
    dqm_nxt    = 2'b11;
    dq_out_nxt = sd_dq_out;
    oe_nxt     = 1'b0;
    ack_nxt    = 1'b0;
    rdy_nxt    = 1'b0;
    rd_nxt     = data_read;
    ref_dec    = 1'b0;
    case (st)
      ST_INIT_WAIT: if (cnt == '0) begin
        cmd_nxt = CMD_PRE; a_nxt = 13'h0400; cnt_nxt = CW'(TRP - 1); st_nxt = ST_INIT_PRE;
      end
      ST_INIT_PRE: if (cnt == '0) begin
        cmd_nxt = CMD_REF; cnt_nxt = CW'(TRFC - 1); st_nxt = ST_INIT_REF1;
      end
      ST_INIT_REF1: if (cnt == '0) begin
        cmd_nxt = CMD_REF; cnt_nxt = CW'(TRFC - 1); st_nxt = ST_INIT_REF2;
      end
      ST_INIT_REF2: if (cnt == '0) begin
        cmd_nxt = CMD_MRS; a_nxt = MODE_REG; ba_nxt = 2'b00; cnt_nxt = CW'(1); st_nxt = ST_INIT_MRS;
      end
      ST_INIT_MRS: if (cnt == '0) st_nxt = ST_IDLE;
      ST_IDLE: begin
        if (ref_urg || (ref_pend && refresh_en)) begin
          cmd_nxt = CMD_REF; ref_dec = 1'b1; cnt_nxt = CW'(TRFC - 2); st_nxt = ST_WAIT;
        end else if (downloading && prog_we) begin
          cmd_nxt = CMD_ACT; ba_nxt = prog_addr[21:20]; a_nxt = {2'b00, prog_addr[19:9]};
          rq_nxt.wr = 1'b1; rq_nxt.col = prog_addr[8:0];
          rq_nxt.data = prog_data; rq_nxt.mask = prog_mask;
          cnt_nxt = CW'(TRCD - 1); st_nxt = ST_ACT;
        end else if (sdram_req) begin
          cmd_nxt = CMD_ACT; ba_nxt = sdram_addr[21:20]; a_nxt = {2'b00, sdram_addr[19:9]};
          rq_nxt.wr = 1'b0; rq_nxt.col = sdram_addr[8:0];
          ack_nxt = 1'b1; cnt_nxt = CW'(TRCD - 1); st_nxt = ST_ACT;
        end
      end
      ST_ACT: if (cnt == '0) begin
        a_nxt = {2'b00, 1'b1, 1'b0, rq.col};
        if (rq.wr) begin
          cmd_nxt = CMD_WR; dq_out_nxt = {rq.data, rq.data}; oe_nxt = 1'b1;
          dqm_nxt = rq.mask; ack_nxt = 1'b1; cnt_nxt = CW'(TRP); st_nxt = ST_WAIT;
        end else begin
          cmd_nxt = CMD_RD; dqm_nxt = 2'b00; cnt_nxt = CW'(CL + 1); st_nxt = ST_RD;
        end
      end
      ST_RD: begin
        dqm_nxt = 2'b00;
        if (cnt == '0) begin
          // dq_r holds the first word; the second is still on the pins
          dqm_nxt = 2'b11; rdy_nxt = 1'b1; rd_nxt = {sd_dq_in, dq_r};
          cnt_nxt = CW'(TRP - 2); st_nxt = ST_WAIT;
        end
      end
      ST_WAIT: if (cnt == '0) st_nxt = ST_IDLE;
      default: st_nxt = ST_INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_INIT_WAIT;
      cnt       <= CW'(INIT_WAIT - 1);
      rq        <= '0;
      dq_r      <= 16'd0;
      sd_cmd    <= CMD_NOP;
      sd_a      <= 13'd0;
      sd_ba     <= 2'b00;
      sd_dqm    <= 2'b11;
      sd_dq_out <= 16'd0;
      sd_dq_oe  <= 1'b0;
      sdram_ack <= 1'b0;
      data_rdy  <= 1'b0;
      data_read <= 32'd0;
      init_done <= 1'b0;
    end else begin
      st        <= st_nxt;
      cnt       <= cnt_nxt;
      rq        <= rq_nxt;
      dq_r      <= sd_dq_in;
      sd_cmd    <= cmd_nxt;
      sd_a      <= a_nxt;
      sd_ba     <= ba_nxt;
      sd_dqm    <= dqm_nxt;
      sd_dq_out <= dq_out_nxt;
      sd_dq_oe  <= oe_nxt;
      sdram_ack <= ack_nxt;
      data_rdy  <= rdy_nxt;
      data_read <= rd_nxt;
      init_done <= init_done | (st == ST_INIT_MRS && cnt == '0);
    end
  end

endmodule

// File: doc/jtcontra_sdram.md
Name: jtcontra_sdram

Overview:
- SDRAM-side responder for the game's ROM request bus (`sdram_req`/`sdram_addr`/`sdram_ack`/`data_rdy`/`data_read`/`refresh_en`).
- Also services download writes (`prog_*`).
- Converts each read request into ACTIVE / READ-with-auto-precharge on a 16-bit SDR SDRAM, returning two consecutive words as one 32-bit result.
- Owns power-up initialisation and auto-refresh scheduling. Sits between the game top level and the SDRAM pins.

Parameters:
- INIT_WAIT, 4800, cycles of NOP after reset before the init sequence (100 µs at 48 MHz).
- REF_CYCLES, 372, cycles per refresh interval (7.8 µs at 48 MHz).
- TRCD, 2, cycles from ACTIVE to READ/WRITE.
- TRP, 2, cycles after PRECHARGE.
- TRFC, 7, cycles after AUTO REFRESH.
- CL, 2, CAS latency; must match the mode register.

Ports:
- clk  in  1  game clock.
- rst  in  1  synchronous reset, active high.
- sdram_req  in  1  read request, level; held by the requester until ack.
- sdram_addr  in  22  16-bit word address.
- sdram_ack  out  1  one-cycle pulse when a request (read or write) is accepted.
- data_rdy  out  1  one-cycle pulse, data_read valid.
- data_read  out  32  {word addr+1, word addr}.
- refresh_en  in  1  requester permits refresh now.
- downloading  in  1  download in progress; writes are serviced only while high.
- prog_we  in  1  write request, level; held until sdram_ack.
- prog_addr  in  22  write word address.
- prog_data  in  8  byte, replicated on both lanes.
- prog_mask  in  2  active-low byte enables; bit0 = low byte.
- init_done  out  1  high once the init sequence is complete.
- sd_cmd  out  4  {nCS,nRAS,nCAS,nWE}.
- sd_a  out  13  address pins.
- sd_ba  out  2  bank.
- sd_dqm  out  2  {DQMH,DQML}.
- sd_dq_out  out  16  write data.
- sd_dq_oe  out  1  data output enable.
- sd_dq_in  in  16  read data (registered inside the block).
- sd_cke  out  1  clock enable.

Behaviour:
- Reset values:
  - sd_cmd = NOP, sd_cke = 1, sd_dqm = 2'b11, sd_dq_oe = 0.
  - sdram_ack, data_rdy, init_done = 0; data_read = 0.
  - FSM = INIT_WAIT.
- Reset asserted mid-operation aborts immediately with no completion pulses; the full init sequence is re-run.
- Address map:
  - sd_ba = addr[21:20].
  - Row = {2'b00, addr[19:9]}.
  - Column = addr[8:0]; sd_a[10] = 1 on READ/WRITE (auto-precharge).
- Init sequence:
  - INIT_WAIT counter.
  - PRECHARGE ALL (A10 = 1), wait TRP.
  - Two AUTO REFRESH, each followed by TRFC.
  - LOAD MODE with sd_a = 13'b000_1_00_010_0_001 (burst length 2, sequential, CL2, single-location writes).
  - Wait 2 cycles, then init_done = 1 and go to IDLE.
- Refresh timer:
  - Counts REF_CYCLES, then increments a pending counter (saturates at 8).
  - Every AUTO REFRESH decrements it.
- IDLE priority, highest first:
  1. Pending == 8 → refresh regardless of refresh_en.
  2. Pending > 0 and refresh_en → refresh.
  3. downloading & prog_we → write.
  4. sdram_req → read.
  5. Otherwise NOP.
- Refresh: REF command, then wait TRFC, then back to IDLE.
- Read (FSM samples request at cycle T):
  - T+1: ACTIVE; sdram_ack = 1; address latched.
  - T+1+TRCD: READ.
  - Words captured at READ+CL+1 (low) and READ+CL+2 (high).
  - data_rdy pulses at READ+CL+2 with data_read updated the same cycle.
  - Then wait TRP and return to IDLE.
  - sdram_req held after ack is not re-serviced until data_rdy; the requester deasserts or changes address after data_rdy.
- Write:
  - T+1: ACTIVE.
  - T+1+TRCD: WRITE with sd_dq_oe = 1, sd_dq_out = {prog_data, prog_data}, sd_dqm = prog_mask, sdram_ack = 1.
  - Then TRP + 2 cycles (write recovery) before IDLE.
  - No data_rdy for writes.
- sd_dqm = 2'b00 during reads; 2'b11 in all other states except WRITE.
- Simultaneous request and refresh due: refresh wins per the priority list; the request waits with no ack.
- sdram_req or prog_we before init_done: ignored.

Decomposition:
- Package jtcontra_sdram_pkg holds:
  - Command encodings: NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010, REF 0001, MRS 0000.
  - MODE_REG constant.
  - FSM state enum.
- Sub-module jtcontra_sdram_refcnt: refresh interval counter plus saturating pending counter, with a decrement input and pending/urgent outputs.

Test Plan:
- Release rst → after INIT_WAIT the command sequence is PRE (A10 = 1), REF, REF, MRS with sd_a = 0x0221; init_done rises 2 cycles after MRS.
- Read at 22'h01_0203 after init, SDRAM model returns 0x1234 then 0x5678:
  - ACT with ba = 0 and row 0x081, ack high that cycle.
  - RD with col 0x003 and A10 = 1 two cycles later.
  - data_rdy 4 cycles after RD, data_read = 32'h5678_1234.
- Write with downloading = 1, prog_we = 1, prog_addr = 22'h2_0000, prog_data = 8'hA5, prog_mask = 2'b10:
  - WR with ba = 0, row 0x100, sd_dq_out = 16'hA5A5, sd_dqm = 2'b10, sd_dq_oe = 1.
  - sdram_ack pulses exactly once.
- refresh_en = 0 with continuous reads:
  - No REF until pending reaches 8 (8×REF_CYCLES).
  - Then REF is forced ahead of the queued sdram_req.
  - Setting refresh_en = 1 drains pending with back-to-back REFs spaced TRFC.
- rst asserted one cycle after ack of a read:
  - No data_rdy; outputs return to reset values; the init sequence repeats.
